// File: rtl/ldpc_byte_pack_pkg.sv
// Shared constants and types for the LDPC byte packer and the byte
// deinterleaver parameter logic.
package ldpc_byte_pack_pkg;

  // Information bytes per LDPC block for each code rate.
  localparam int unsigned BLK_BYTES_R12 = 576;
  localparam int unsigned BLK_BYTES_R34 = 864;

  // LDPC blocks per frame for ofdm_mode=1, bydin_mode=001.
  localparam int unsigned BLK_BASE      = 15;

  // Counter widths.
  localparam int unsigned BIT_CNT_W     = 3;
  localparam int unsigned BYTE_CNT_W    = 10;
  localparam int unsigned BLK_CNT_W     = 7;

  // One-hot deinterleaver mode codes (shared with the deinterleaver mi table).
  localparam logic [2:0] BYDIN_M1 = 3'b001;
  localparam logic [2:0] BYDIN_M2 = 3'b010;
  localparam logic [2:0] BYDIN_M4 = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Per-cycle control strobes decoded from state and inputs.
  typedef struct packed {
    logic load;     // latch frame configuration
    logic capture;  // current bit becomes bit 7 of byte 0 of a block
    logic accept;   // current bit is packed into the running byte
    logic emit;     // current bit completes a byte
    logic blk_end;  // completed byte is the last of its block
    logic frm_end;  // completed byte is the last of the frame
    logic err;      // framing error this cycle
    logic win_clr;  // force byte_win low next cycle
    logic cnt_clr;  // clear all counters (frame abandoned)
  } pack_ctl_t;

  function automatic logic bydin_valid(input logic [2:0] mode);
    return (mode == BYDIN_M1) || (mode == BYDIN_M2) || (mode == BYDIN_M4);
  endfunction

  // Block-count multiplier for a deinterleaver mode; invalid codes map to 1
  // but are never latched.
  function automatic int unsigned bydin_mult(input logic [2:0] mode);
    int unsigned m;
    unique case (mode)
      BYDIN_M2: m = 2;
      BYDIN_M4: m = 4;
      default:  m = 1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ldpc_frm_cfg.sv
// Frame configuration lookup: blocks per frame and bytes per block from the
// mode inputs, plus the register that holds them for the whole frame.
module ldpc_frm_cfg #(
  parameter int unsigned BLK_BYTES_R12 = ldpc_byte_pack_pkg::BLK_BYTES_R12,
  parameter int unsigned BLK_BYTES_R34 = ldpc_byte_pack_pkg::BLK_BYTES_R34,
  parameter int unsigned BLK_BASE      = ldpc_byte_pack_pkg::BLK_BASE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_ofdm_mode,
  input  logic       i_ldpc_rate,
  input  logic [2:0] i_bydin_mode,
  output logic       o_mode_ok,
  output logic [6:0] o_nblk,
  output logic [9:0] o_blk_bytes
);
  import ldpc_byte_pack_pkg::*;

  logic [6:0] w_nblk;
  logic [9:0] w_blk_bytes;
  logic [6:0] r_nblk;
  logic [9:0] r_blk_bytes;

  // Combinational lookup from the live mode inputs.
  always_comb begin
    o_mode_ok   = bydin_valid(i_bydin_mode);
    w_nblk      = 7'(BLK_BASE * (i_ofdm_mode ? 32'd1 : 32'd2) * bydin_mult(i_bydin_mode));
    w_blk_bytes = i_ldpc_rate ? 10'(BLK_BYTES_R34) : 10'(BLK_BYTES_R12);
  end

  // Hold the looked-up values from frame_start until the next frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nblk      <= '0;
      r_blk_bytes <= '0;
    end else if (i_load) begin
      r_nblk      <= w_nblk;
      r_blk_bytes <= w_blk_bytes;
    end
  end

  assign o_nblk      = r_nblk;
  assign o_blk_bytes = r_blk_bytes;

endmodule

// File: rtl/ldpc_byte_pack.sv
// Packs serial LDPC information bits MSB-first into bytes and frames them
// for the byte deinterleaver (byte_sync / byte_data / byte_win), counting
// blocks per frame and flagging framing errors.
module ldpc_byte_pack #(
  parameter int unsigned BLK_BYTES_R12 = ldpc_byte_pack_pkg::BLK_BYTES_R12,
  parameter int unsigned BLK_BYTES_R34 = ldpc_byte_pack_pkg::BLK_BYTES_R34,
  parameter int unsigned BLK_BASE      = ldpc_byte_pack_pkg::BLK_BASE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ldpc_en,
  input  logic       ldpc_bit,
  input  logic       ldpc_sob,
  input  logic       frame_start,
  input  logic       ofdm_mode,
  input  logic       ldpc_rate,
  input  logic [2:0] bydin_mode,
  output logic       byte_sync,
  output logic [7:0] byte_data,
  output logic       byte_win,
  output logic       frame_done,
  output logic       err_pulse
);
  import ldpc_byte_pack_pkg::*;

  state_t                r_state;
  state_t                w_state_nxt;
  pack_ctl_t             w_ctl;

  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [BLK_CNT_W-1:0]  r_blk_cnt;
  logic [6:0]            r_shift;

  logic                  r_sync;
  logic [7:0]            r_data;
  logic                  r_win;
  logic                  r_done;
  logic                  r_err;

  logic                  w_sob;
  logic                  w_fs;
  logic                  w_mode_ok;
  logic [6:0]            w_nblk;
  logic [9:0]            w_blk_bytes;
  logic                  w_last_byte;
  logic                  w_last_blk;
  logic                  w_mid_block;
  logic [7:0]            w_byte;

  ldpc_frm_cfg #(
    .BLK_BYTES_R12 (BLK_BYTES_R12),
    .BLK_BYTES_R34 (BLK_BYTES_R34),
    .BLK_BASE      (BLK_BASE)
  ) u_cfg (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_load       (w_ctl.load),
    .i_ofdm_mode  (ofdm_mode),
    .i_ldpc_rate  (ldpc_rate),
    .i_bydin_mode (bydin_mode),
    .o_mode_ok    (w_mode_ok),
    .o_nblk       (w_nblk),
    .o_blk_bytes  (w_blk_bytes)
  );

  // Qualified input events and position decodes.
  always_comb begin
    w_sob       = ldpc_en & ldpc_sob;
    w_fs        = w_sob & frame_start;
    w_last_byte = (r_byte_cnt == (w_blk_bytes - 10'd1));
    w_last_blk  = (r_blk_cnt == (w_nblk - 7'd1));
    w_mid_block = (r_bit_cnt != '0) || (r_byte_cnt != '0);
    w_byte      = {r_shift, ldpc_bit};
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Control decode: what the current cycle's input means in this state.
  always_comb begin
    w_ctl = '0;
    unique case (r_state)
      IDLE: begin
        if (w_fs) begin
          if (w_mode_ok) begin
            w_ctl.load    = 1'b1;
            w_ctl.capture = 1'b1;
          end else begin
            w_ctl.err     = 1'b1;
            w_ctl.win_clr = 1'b1;
            w_ctl.cnt_clr = 1'b1;
          end
        end
      end
      PACK: begin
        if (w_fs) begin
          w_ctl.err     = 1'b1;
          w_ctl.win_clr = 1'b1;
          if (w_mode_ok) begin
            w_ctl.load    = 1'b1;
            w_ctl.capture = 1'b1;
          end else begin
            w_ctl.cnt_clr = 1'b1;
          end
        end else if (w_sob && w_mid_block) begin
          w_ctl.err     = 1'b1;
          w_ctl.capture = 1'b1;
        end else if (ldpc_en) begin
          w_ctl.accept = 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_ctl.emit    = 1'b1;
            w_ctl.blk_end = w_last_byte;
            w_ctl.frm_end = w_last_byte & w_last_blk;
          end
        end
      end
      GAP: begin
        if (w_fs) begin
          w_ctl.err     = 1'b1;
          w_ctl.win_clr = 1'b1;
          if (w_mode_ok) begin
            w_ctl.load    = 1'b1;
            w_ctl.capture = 1'b1;
          end else begin
            w_ctl.cnt_clr = 1'b1;
          end
        end else if (w_sob) begin
          w_ctl.capture = 1'b1;
        end else if (ldpc_en) begin
          w_ctl.err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next state: every capture lands in PACK; abandonment and frame end go
  // to IDLE; a finished block waits in GAP.
  always_comb begin
    w_state_nxt = r_state;
    if (w_ctl.capture)      w_state_nxt = PACK;
    else if (w_ctl.cnt_clr) w_state_nxt = IDLE;
    else if (w_ctl.frm_end) w_state_nxt = IDLE;
    else if (w_ctl.blk_end) w_state_nxt = GAP;
  end

  // Bit shifter: every packed or captured bit enters at the LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            r_shift <= '0;
    else if (w_ctl.capture || w_ctl.accept)  r_shift <= {r_shift[5:0], ldpc_bit};
  end

  // Bit, byte and block counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_blk_cnt  <= '0;
    end else if (w_ctl.cnt_clr) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_blk_cnt  <= '0;
    end else if (w_ctl.capture) begin
      // A mid-block restart keeps blk_cnt; only a new frame rewinds it.
      r_bit_cnt  <= 3'd1;
      r_byte_cnt <= '0;
      if (w_ctl.load) r_blk_cnt <= '0;
    end else if (w_ctl.accept) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_ctl.emit) begin
        if (w_ctl.blk_end) begin
          r_byte_cnt <= '0;
          r_blk_cnt  <= w_ctl.frm_end ? '0 : r_blk_cnt + 7'd1;
        end else begin
          r_byte_cnt <= r_byte_cnt + 10'd1;
        end
      end
    end
  end

  // Registered outputs, one cycle after the completing bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 1'b0;
      r_data <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_sync <= w_ctl.emit;
      r_done <= w_ctl.frm_end;
      r_err  <= w_ctl.err;
      if (w_ctl.emit) r_data <= w_byte;
    end
  end

  // Frame window: rises with the first byte_sync, falls the cycle after
  // frame_done or immediately after an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           r_win <= 1'b0;
    else if (w_ctl.win_clr) r_win <= 1'b0;
    else if (w_ctl.emit)    r_win <= 1'b1;
    else if (r_done)        r_win <= 1'b0;
  end

  assign byte_sync  = r_sync;
  assign byte_data  = r_data;
  assign byte_win   = r_win;
  assign frame_done = r_done;
  assign err_pulse  = r_err;

endmodule

// File: tb/tb_ldpc_byte_pack.sv
// Bench for ldpc_byte_pack with reduced block sizes: table of frame
// configurations plus hand-written error and reset sequences; expected
// bytes go into a scoreboard queue as bits are driven.
module tb_ldpc_byte_pack;

  localparam int unsigned T_R12  = 4;
  localparam int unsigned T_R34  = 6;
  localparam int unsigned T_BASE = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ldpc_en = 1'b0;
  logic       ldpc_bit = 1'b0;
  logic       ldpc_sob = 1'b0;
  logic       frame_start = 1'b0;
  logic       ofdm_mode = 1'b0;
  logic       ldpc_rate = 1'b0;
  logic [2:0] bydin_mode = 3'b000;
  logic       byte_sync;
  logic [7:0] byte_data;
  logic       byte_win;
  logic       frame_done;
  logic       err_pulse;

  always #5 clk = ~clk;

  ldpc_byte_pack #(
    .BLK_BYTES_R12 (T_R12),
    .BLK_BYTES_R34 (T_R34),
    .BLK_BASE      (T_BASE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ldpc_en     (ldpc_en),
    .ldpc_bit    (ldpc_bit),
    .ldpc_sob    (ldpc_sob),
    .frame_start (frame_start),
    .ofdm_mode   (ofdm_mode),
    .ldpc_rate   (ldpc_rate),
    .bydin_mode  (bydin_mode),
    .byte_sync   (byte_sync),
    .byte_data   (byte_data),
    .byte_win    (byte_win),
    .frame_done  (frame_done),
    .err_pulse   (err_pulse)
  );

  typedef struct {
    logic [7:0]  data;
    logic        done;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic        ofdm;
    logic        rate;
    logic [2:0]  bydin;
    int unsigned nblk;
    int unsigned bb;
    int unsigned gap;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned err_seen = 0;
  int unsigned done_seen = 0;
  logic        prev_done = 1'b0;
  logic [7:0]  last_data = 8'h00;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard on every byte_sync.
  always @(negedge clk) begin
    exp_t e;
    if (err_pulse)  err_seen++;
    if (frame_done) done_seen++;
    if (prev_done) chk("win_after_done", byte_win, 0);
    prev_done = frame_done;
    if (byte_sync) begin
      chk("sync_in_win", byte_win, 1);
      if (sb.size() == 0) begin
        fail_now("unexpected_sync", byte_data, 0);
      end else begin
        e = sb.pop_front();
        chk("byte_data", byte_data, e.data);
        chk("frame_done", frame_done, e.done);
        chk("sync_cycle", cyc, e.cyc);
        last_data = byte_data;
      end
    end else if (frame_done) begin
      fail_now("done_without_sync", frame_done, 0);
    end
  end

  task automatic drive(input logic en, input logic b, input logic sob, input logic fs);
    @(posedge clk);
    #1;
    ldpc_en     = en;
    ldpc_bit    = b;
    ldpc_sob    = sob;
    frame_start = fs;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scramble_cfg();
    ofdm_mode  = 1'($urandom_range(1));
    ldpc_rate  = 1'($urandom_range(1));
    bydin_mode = 3'($urandom_range(7));
  endtask

  task automatic send_byte(input logic [7:0] v, input logic sob, input logic fs, input logic done);
    exp_t e;
    for (int i = 7; i >= 0; i--) drive(1'b1, v[i], sob && (i == 7), fs && (i == 7));
    e.data = v;
    e.done = done;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic send_block(input int unsigned nbytes, input logic fs, input logic last, input logic a5);
    logic [7:0] v;
    for (int unsigned j = 0; j < nbytes; j++) begin
      v = (a5 && j == 0) ? 8'hA5 : 8'($urandom_range(255));
      send_byte(v, j == 0, fs && (j == 0), last && (j == nbytes - 1));
      if (fs && j == 0) scramble_cfg();
    end
  endtask

  task automatic set_cfg(input vec_t c);
    ofdm_mode  = c.ofdm;
    ldpc_rate  = c.rate;
    bydin_mode = c.bydin;
  endtask

  task automatic send_frame(input vec_t c, input logic a5, input logic gap_noise);
    for (int unsigned b = 0; b < c.nblk; b++) begin
      if (b == 0) set_cfg(c);
      send_block(c.bb, b == 0, b == c.nblk - 1, a5 && (b == 0));
      if (b != c.nblk - 1) begin
        for (int unsigned g = 0; g < c.gap; g++) begin
          drive(gap_noise && (g == 0), 1'b1, 1'b0, 1'b0);
          chk("gap_win", byte_win, 1);
          if (g > 0) chk("data_hold", byte_data, last_data);
        end
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("drain_empty", sb.size(), 0);
    sb.delete();
    idle(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned eb;
    int unsigned db;
    vec_t        cc;
    logic [7:0]  v;

    vecs[0] = '{1'b1, 1'b0, 3'b001,  3, 4, 0};
    vecs[1] = '{1'b0, 1'b1, 3'b100, 24, 6, 5};
    vecs[2] = '{1'b1, 1'b1, 3'b010,  6, 6, 0};
    vecs[3] = '{1'b0, 1'b0, 3'b010, 12, 4, 2};
    vecs[4] = '{1'b1, 1'b0, 3'b100, 12, 4, 0};
    vecs[5] = '{1'b0, 1'b1, 3'b001,  6, 6, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sync", byte_sync, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_win", byte_win, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", err_pulse, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Table of frame configurations
    for (int v_i = 0; v_i < 6; v_i++) begin
      eb = err_seen;
      db = done_seen;
      send_frame(vecs[v_i], v_i == 0, 1'b0);
      drain();
      chk($sformatf("vec%0d_err", v_i), err_seen - eb, 0);
      chk($sformatf("vec%0d_frames", v_i), done_seen - db, 1);
      chk($sformatf("vec%0d_win_low", v_i), byte_win, 0);
    end

    // sob inside block 2, byte 2, after 3 bits: restart the block
    eb = err_seen;
    db = done_seen;
    set_cfg(vecs[0]);
    send_block(4, 1'b1, 1'b0, 1'b0);
    send_block(4, 1'b0, 1'b0, 1'b0);
    send_byte(8'($urandom_range(255)), 1'b1, 1'b0, 1'b0);
    send_byte(8'($urandom_range(255)), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    send_block(4, 1'b0, 1'b1, 1'b0);
    drain();
    chk("midsob_err", err_seen - eb, 1);
    chk("midsob_frames", done_seen - db, 1);

    // ldpc_en without sob in GAP: bit dropped, one error per gap
    eb = err_seen;
    db = done_seen;
    cc = '{1'b1, 1'b0, 3'b001, 3, 4, 2};
    send_frame(cc, 1'b0, 1'b1);
    drain();
    chk("gapbit_err", err_seen - eb, 2);
    chk("gapbit_frames", done_seen - db, 1);

    // Invalid bydin_mode at frame_start, then a valid frame
    eb = err_seen;
    db = done_seen;
    ofdm_mode  = 1'b1;
    ldpc_rate  = 1'b0;
    bydin_mode = 3'b011;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 15; k++) drive(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    idle(3);
    chk("badmode_err", err_seen - eb, 1);
    chk("badmode_win", byte_win, 0);
    chk("badmode_frames", done_seen - db, 0);
    eb = err_seen;
    send_frame(vecs[0], 1'b0, 1'b0);
    drain();
    chk("after_badmode_err", err_seen - eb, 0);
    chk("after_badmode_frames", done_seen - db, 1);

    // frame_start mid-frame: abort, window drops, new frame runs
    eb = err_seen;
    db = done_seen;
    set_cfg(vecs[2]);
    send_block(6, 1'b1, 1'b0, 1'b0);
    send_byte(8'($urandom_range(255)), 1'b1, 1'b0, 1'b0);
    send_byte(8'($urandom_range(255)), 1'b0, 1'b0, 1'b0);
    chk("pre_abort_win", byte_win, 1);
    fork
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_win", byte_win, 0);
      end
    join_none
    send_frame(vecs[0], 1'b0, 1'b0);
    drain();
    chk("abort_err", err_seen - eb, 1);
    chk("abort_frames", done_seen - db, 1);

    // Asynchronous reset while a byte_sync is on the outputs
    set_cfg(vecs[0]);
    send_block(4, 1'b1, 1'b0, 1'b0);
    v = 8'($urandom_range(255));
    send_byte(v, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_sync", byte_sync, 1);
    ldpc_en     = 1'b0;
    ldpc_sob    = 1'b0;
    frame_start = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_sync", byte_sync, 0);
    chk("arst_data", byte_data, 0);
    chk("arst_win", byte_win, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_err", err_pulse, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    eb = err_seen;
    db = done_seen;
    send_frame(vecs[3], 1'b0, 1'b0);
    drain();
    chk("post_rst_err", err_seen - eb, 0);
    chk("post_rst_frames", done_seen - db, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
